// File: rtl/sdram_cmd_responder_if.sv
// Command/data bus between an SDRAM controller (master) and the responder model (slave).
interface sdram_cmd_responder_if #(
  parameter int unsigned DATA_W = 16
);
  logic              mem_cke;
  logic              mem_CSn;
  logic              mem_RASn;
  logic              mem_CASn;
  logic              mem_WEn;
  logic [11:0]       mem_addr;
  logic [DATA_W-1:0] mem_dq_i;
  logic [DATA_W-1:0] mem_dq_o;
  logic              mem_dq_oe;
  logic              cmd_err;
  logic [1:0]        cas_lat;

  modport master (
    output mem_cke, mem_CSn, mem_RASn, mem_CASn, mem_WEn, mem_addr, mem_dq_i,
    input  mem_dq_o, mem_dq_oe, cmd_err, cas_lat
  );

  modport slave (
    input  mem_cke, mem_CSn, mem_RASn, mem_CASn, mem_WEn, mem_addr, mem_dq_i,
    output mem_dq_o, mem_dq_oe, cmd_err, cas_lat
  );
endinterface

// File: rtl/sdram_cmd_responder.sv
// Behavioural single-bank SDRAM device: decodes commands, checks timing/legality,
// stores write data and returns read data after the programmed CAS latency.
module sdram_cmd_responder #(
  parameter int unsigned ROW_BITS = 4,
  parameter int unsigned COL_BITS = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned T_RCD    = 2,
  parameter int unsigned T_RFC    = 4
) (
  input logic                  hclk,
  input logic                  nrst,
  sdram_cmd_responder_if.slave bus
);
  localparam int unsigned AddrW  = ROW_BITS + COL_BITS;
  localparam int unsigned CntMax = (T_RCD > T_RFC) ? T_RCD : T_RFC;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [2:0] {
    StInit, StIdle, StActivating, StRowActive, StRefreshing
  } state_e;

  typedef enum logic [2:0] {
    CmdNop, CmdAct, CmdRead, CmdWrite, CmdPre, CmdRef, CmdLmr, CmdBad
  } cmd_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [ROW_BITS-1:0] row_q, row_d;
  logic [1:0]          cas_q, cas_d;
  logic                err_q, err_d;
  logic                oe_q, oe_d;
  logic [DATA_W-1:0]   dq_q, dq_d;
  logic                p1_vld_q, p1_vld_d, p1_lat3_q, p1_lat3_d;
  logic                p2_vld_q, p2_vld_d, p2_lat3_q, p2_lat3_d;
  logic                p3_vld_q, p3_vld_d;
  logic [DATA_W-1:0]   p1_data_q, p1_data_d, p2_data_q, p2_data_d, p3_data_q, p3_data_d;

  logic [DATA_W-1:0]   mem_q [2**AddrW];
  logic [AddrW-1:0]    mem_idx;
  logic                mem_we;
  logic                lmr_ok;
  cmd_e                cmd;
  logic                unused_addr;

  assign unused_addr = ^bus.mem_addr;
  assign mem_idx     = {row_q, bus.mem_addr[COL_BITS-1:0]};
  assign lmr_ok      = (bus.mem_addr[6:5] == 2'b01);

  always_comb begin
    cmd = CmdBad;
    unique casez ({bus.mem_CSn, bus.mem_RASn, bus.mem_CASn, bus.mem_WEn})
      4'b1???: cmd = CmdNop;
      4'b0111: cmd = CmdNop;
      4'b0011: cmd = CmdAct;
      4'b0101: cmd = CmdRead;
      4'b0100: cmd = CmdWrite;
      4'b0010: cmd = CmdPre;
      4'b0001: cmd = CmdRef;
      4'b0000: cmd = CmdLmr;
      default: cmd = CmdBad;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    row_d     = row_q;
    cas_d     = cas_q;
    err_d     = 1'b0;
    oe_d      = oe_q;
    dq_d      = dq_q;
    p1_vld_d  = p1_vld_q;
    p1_lat3_d = p1_lat3_q;
    p1_data_d = p1_data_q;
    p2_vld_d  = p2_vld_q;
    p2_lat3_d = p2_lat3_q;
    p2_data_d = p2_data_q;
    p3_vld_d  = p3_vld_q;
    p3_data_d = p3_data_q;
    mem_we    = 1'b0;

    if (bus.mem_cke) begin
      // Read data is captured at issue, so a following WRITE cannot disturb it.
      p1_vld_d  = 1'b0;
      p1_lat3_d = (cas_q == 2'd3);
      p1_data_d = mem_q[mem_idx];
      p2_vld_d  = p1_vld_q;
      p2_lat3_d = p1_lat3_q;
      p2_data_d = p1_data_q;
      p3_vld_d  = p2_vld_q & p2_lat3_q;
      p3_data_d = p2_data_q;
      if (p2_vld_q && !p2_lat3_q) begin
        oe_d = 1'b1;
        dq_d = p2_data_q;
      end else if (p3_vld_q) begin
        oe_d = 1'b1;
        dq_d = p3_data_q;
      end else begin
        oe_d = 1'b0;
        dq_d = '0;
      end

      unique case (state_q)
        StInit, StIdle: begin
          unique case (cmd)
            CmdNop, CmdPre: ;
            CmdLmr: begin
              if (lmr_ok) begin
                cas_d   = bus.mem_addr[5:4];
                state_d = StIdle;
              end else begin
                err_d = 1'b1;
              end
            end
            CmdRef: begin
              if (state_q == StIdle) begin
                cnt_d   = CntW'(T_RFC - 1);
                state_d = StRefreshing;
              end
            end
            CmdAct: begin
              if (state_q == StIdle) begin
                row_d   = bus.mem_addr[ROW_BITS-1:0];
                cnt_d   = CntW'(T_RCD - 1);
                state_d = StActivating;
              end else begin
                err_d = 1'b1;
              end
            end
            default: err_d = 1'b1;
          endcase
        end
        StActivating, StRefreshing: begin
          if (cnt_q <= CntW'(1)) begin
            cnt_d   = '0;
            state_d = (state_q == StActivating) ? StRowActive : StIdle;
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
          err_d = (cmd != CmdNop);
        end
        StRowActive: begin
          unique case (cmd)
            CmdNop:   ;
            CmdWrite: mem_we = 1'b1;
            CmdRead:  p1_vld_d = 1'b1;
            CmdPre:   state_d = StIdle;
            default:  err_d = 1'b1;
          endcase
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge hclk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StInit;
      cnt_q     <= '0;
      row_q     <= '0;
      cas_q     <= 2'd2;
      err_q     <= 1'b0;
      oe_q      <= 1'b0;
      dq_q      <= '0;
      p1_vld_q  <= 1'b0;
      p1_lat3_q <= 1'b0;
      p1_data_q <= '0;
      p2_vld_q  <= 1'b0;
      p2_lat3_q <= 1'b0;
      p2_data_q <= '0;
      p3_vld_q  <= 1'b0;
      p3_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      row_q     <= row_d;
      cas_q     <= cas_d;
      err_q     <= err_d;
      oe_q      <= oe_d;
      dq_q      <= dq_d;
      p1_vld_q  <= p1_vld_d;
      p1_lat3_q <= p1_lat3_d;
      p1_data_q <= p1_data_d;
      p2_vld_q  <= p2_vld_d;
      p2_lat3_q <= p2_lat3_d;
      p2_data_q <= p2_data_d;
      p3_vld_q  <= p3_vld_d;
      p3_data_q <= p3_data_d;
    end
  end

  // Array contents survive reset.
  always_ff @(posedge hclk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= bus.mem_dq_i;
    end
  end

  assign bus.mem_dq_o  = dq_q;
  assign bus.mem_dq_oe = oe_q;
  assign bus.cmd_err   = err_q;
  assign bus.cas_lat   = cas_q;
endmodule

// File: tb/tb_sdram_cmd_responder.sv
// Directed and random stimulus for sdram_cmd_responder, checked against a timestamp-based
// model of the device rules (legality windows, per-read delivery times, word array).
module tb_sdram_cmd_responder;
  localparam int unsigned TRcd = 2;
  localparam int unsigned TRfc = 4;

  localparam logic [3:0] CmdNop = 4'b0111;
  localparam logic [3:0] CmdAct = 4'b0011;
  localparam logic [3:0] CmdRd  = 4'b0101;
  localparam logic [3:0] CmdWr  = 4'b0100;
  localparam logic [3:0] CmdPre = 4'b0010;
  localparam logic [3:0] CmdRef = 4'b0001;
  localparam logic [3:0] CmdLmr = 4'b0000;

  logic        hclk = 1'b0;
  logic        nrst;
  int unsigned checks = 0;
  int unsigned errors = 0;

  sdram_cmd_responder_if #(.DATA_W(16)) bus ();

  sdram_cmd_responder #(
    .ROW_BITS(4),
    .COL_BITS(4),
    .DATA_W  (16),
    .T_RCD   (TRcd),
    .T_RFC   (TRfc)
  ) dut (
    .hclk(hclk),
    .nrst(nrst),
    .bus (bus)
  );

  always #5 hclk = ~hclk;

  // Reference model: time is counted in enabled edges only.
  logic [15:0] ref_mem [256];
  logic [15:0] due [int];
  int          ecyc = 0;
  int          ready_at = 0;
  bit          inited = 1'b0;
  bit          row_open = 1'b0;
  logic [3:0]  open_row = '0;
  int          cas = 2;
  logic        exp_oe = 1'b0;
  logic        exp_err = 1'b0;
  logic [15:0] exp_dq = '0;

  function automatic void model_reset();
    inited   = 1'b0;
    row_open = 1'b0;
    ready_at = 0;
    cas      = 2;
    due.delete();
    exp_oe   = 1'b0;
    exp_dq   = '0;
    exp_err  = 1'b0;
  endfunction

  function automatic void load_mode(input logic [11:0] a);
    if (a[6:4] == 3'd2 || a[6:4] == 3'd3) begin
      cas    = int'(a[6:4]);
      inited = 1'b1;
    end else begin
      exp_err = 1'b1;
    end
  endfunction

  function automatic void model_edge(input logic [3:0] c, input logic [11:0] a,
                                     input logic [15:0] d, input logic k);
    logic [7:0] idx;
    if (!k) begin
      exp_err = 1'b0;
    end else begin
      ecyc++;
      exp_err = 1'b0;
      if (due.exists(ecyc)) begin
        exp_oe = 1'b1;
        exp_dq = due[ecyc];
        due.delete(ecyc);
      end else begin
        exp_oe = 1'b0;
        exp_dq = '0;
      end
      idx = {open_row, a[3:0]};
      if (c[3] || c == CmdNop) begin
        // no-op
      end else if (!inited) begin
        if (c == CmdLmr) load_mode(a);
        else if (c != CmdPre && c != CmdRef) exp_err = 1'b1;
      end else if (ecyc < ready_at) begin
        exp_err = 1'b1;
      end else if (row_open) begin
        case (c)
          CmdWr:   ref_mem[idx] = d;
          CmdRd:   due[ecyc + cas] = ref_mem[idx];
          CmdPre:  row_open = 1'b0;
          default: exp_err = 1'b1;
        endcase
      end else begin
        case (c)
          CmdAct: begin
            open_row = a[3:0];
            row_open = 1'b1;
            ready_at = ecyc + TRcd;
          end
          CmdRef:  ready_at = ecyc + TRfc;
          CmdLmr:  load_mode(a);
          CmdPre:  ;
          default: exp_err = 1'b1;
        endcase
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, " oe"}, 32'(bus.mem_dq_oe), 32'(exp_oe));
    chk({where, " dq"}, 32'(bus.mem_dq_o), 32'(exp_dq));
    chk({where, " err"}, 32'(bus.cmd_err), 32'(exp_err));
    chk({where, " cas"}, 32'(bus.cas_lat), 32'(cas));
  endtask

  // Entered and left at a falling edge.
  task automatic tick(input string where, input logic [3:0] c, input logic [11:0] a,
                      input logic [15:0] d, input logic k);
    {bus.mem_CSn, bus.mem_RASn, bus.mem_CASn, bus.mem_WEn} = c;
    bus.mem_addr = a;
    bus.mem_dq_i = d;
    bus.mem_cke  = k;
    @(posedge hclk);
    model_edge(c, a, d, k);
    @(negedge hclk);
    check_outputs(where);
  endtask

  task automatic issue(input string where, input logic [3:0] c, input logic [11:0] a,
                       input logic [15:0] d = 16'h0);
    tick(where, c, a, d, 1'b1);
  endtask

  task automatic nops(input string where, input int n);
    for (int i = 0; i < n; i++) issue(where, CmdNop, 12'h0);
  endtask

  task automatic do_reset(input string where);
    nrst = 1'b0;
    {bus.mem_CSn, bus.mem_RASn, bus.mem_CASn, bus.mem_WEn} = CmdNop;
    #1;
    model_reset();
    check_outputs(where);
    @(negedge hclk);
    @(negedge hclk);
    nrst = 1'b1;
  endtask

  initial begin
    logic [3:0]  c;
    logic [11:0] a;
    logic [15:0] d;
    logic        k;
    int unsigned r;

    nrst         = 1'b1;
    bus.mem_cke  = 1'b1;
    bus.mem_addr = '0;
    bus.mem_dq_i = '0;
    {bus.mem_CSn, bus.mem_RASn, bus.mem_CASn, bus.mem_WEn} = CmdNop;
    #2;
    do_reset("reset");

    issue("read in init", CmdRd, 12'h005);
    nops("after init read", 1);
    issue("lmr cas5 init", CmdLmr, 12'h050);
    nops("after bad lmr", 1);
    issue("lmr cas2", CmdLmr, 12'h020);

    for (int row = 0; row < 16; row++) begin
      issue("fill act", CmdAct, 12'(row));
      nops("fill wait", 1);
      for (int col = 0; col < 16; col++) issue("fill wr", CmdWr, 12'(col), 16'($urandom));
      issue("fill pre", CmdPre, 12'h0);
    end

    issue("bringup act", CmdAct, 12'h003);
    nops("bringup wait", 1);
    issue("bringup wr", CmdWr, 12'h005, 16'hBEEF);
    issue("bringup rd", CmdRd, 12'h005);
    nops("bringup lat1", 1);
    nops("bringup lat2", 1);
    chk("bringup data", 32'(bus.mem_dq_o), 32'h0000_BEEF);
    chk("bringup oe", 32'(bus.mem_dq_oe), 32'h1);
    nops("bringup tail", 1);

    issue("wr then rd wr", CmdWr, 12'h006, 16'h1234);
    issue("wr then rd rd", CmdRd, 12'h006);
    issue("rd then wr rd", CmdRd, 12'h007);
    issue("rd then wr wr", CmdWr, 12'h007, 16'h5678);
    nops("hazard drain", 3);

    issue("act in row active", CmdAct, 12'h004);
    nops("after bad act", 1);

    issue("cke rd", CmdRd, 12'h005);
    tick("cke off act", CmdAct, 12'h001, 16'h0, 1'b0);
    tick("cke off pre", CmdPre, 12'h0, 16'h0, 1'b0);
    tick("cke off wr", CmdWr, 12'h005, 16'hDEAD, 1'b0);
    nops("cke drain", 4);

    issue("pre after rd rd", CmdRd, 12'h006);
    issue("pre after rd pre", CmdPre, 12'h0);
    nops("pre drain", 3);

    issue("read in idle", CmdRd, 12'h005);
    nops("after idle read", 1);
    issue("lmr cas5 idle", CmdLmr, 12'h050);
    nops("after bad lmr", 1);

    issue("refresh", CmdRef, 12'h0);
    issue("act in refresh +1", CmdAct, 12'h002);
    nops("refresh +2", 1);
    issue("act in refresh +3", CmdAct, 12'h002);
    issue("act after trfc", CmdAct, 12'h002);
    issue("wr in activating", CmdWr, 12'h009, 16'hAAAA);
    nops("activating", 1);
    issue("rd row2", CmdRd, 12'h009);
    nops("row2 drain", 3);
    issue("pre row2", CmdPre, 12'h0);

    issue("lmr cas3", CmdLmr, 12'h030);
    chk("cas_lat 3", 32'(bus.cas_lat), 32'd3);
    issue("b2b act", CmdAct, 12'h007);
    nops("b2b wait", 1);
    for (int i = 0; i < 4; i++) issue("b2b rd", CmdRd, 12'(i));
    nops("b2b drain", 5);

    issue("reset rd", CmdRd, 12'h001);
    do_reset("mid-read reset");
    nops("post reset", 5);
    issue("read after reset", CmdRd, 12'h001);
    nops("post reset tail", 1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 19);
      a = 12'($urandom);
      d = 16'($urandom);
      k = ($urandom_range(0, 9) != 0);
      case (r)
        6:       c = {1'b1, 3'($urandom)};
        7, 8, 9: c = CmdRd;
        10, 11:  c = CmdWr;
        12, 13:  c = CmdAct;
        14:      c = CmdPre;
        15:      c = CmdRef;
        16:      c = CmdLmr;
        default: c = CmdNop;
      endcase
      tick("random", c, a, d, k);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sdram_cmd_responder.md
SDRAM_CMD_RESPONDER -- requirements
Module: sdram_cmd_responder

Interface
REQ-001 Parameter ROW_BITS, default 4, row address width; A[ROW_BITS-1:0] is latched on ACTIVE.
REQ-002 Parameter COL_BITS, default 4, column address width; A[COL_BITS-1:0] is used on READ/WRITE.
REQ-003 Parameter DATA_W, default 16, data word width.
REQ-004 Parameter T_RCD, default 2, cycles from ACTIVE until READ/WRITE is legal.
REQ-005 Parameter T_RFC, default 4, cycles an AUTO REFRESH occupies.
REQ-006 hclk  in  1  clock; all sampling on rising edge.
REQ-007 nrst  in  1  reset; asynchronous, active-low.
REQ-008 mem_cke  in  1  clock enable; 0 freezes all state, counters and read pipeline.
REQ-009 mem_CSn, mem_RASn, mem_CASn, mem_WEn  in  1 each  command strobes.
REQ-010 mem_addr  in  12  address/mode bus.
REQ-011 mem_dq_i  in  DATA_W  write data.
REQ-012 mem_dq_o  out  DATA_W  read data.
REQ-013 mem_dq_oe  out  1  read data valid / drive enable.
REQ-014 cmd_err  out  1  one-cycle pulse on an illegal command.
REQ-015 cas_lat  out  2  current CAS latency (2 or 3).

Function
REQ-016 Decode {CSn,RASn,CASn,WEn}: 1xxx DESELECT and 0111 NOP (both no-op); 0011 ACTIVE; 0101 READ; 0100 WRITE; 0010 PRECHARGE; 0001 AUTO REFRESH; 0000 LOAD MODE.
REQ-017 Commands are sampled only when mem_cke=1.
REQ-018 Storage: 2^(ROW_BITS+COL_BITS) words of DATA_W, indexed {open_row, column}.
REQ-019 State machine states: INIT, IDLE, ACTIVATING, ROW_ACTIVE, REFRESHING.
REQ-020 INIT: LOAD MODE -> IDLE; NOP/DESELECT/PRECHARGE/AUTO REFRESH are accepted with no state change; any other command -> cmd_err.
REQ-021 LOAD MODE takes mem_addr[6:4] as the CAS latency. Value 2 or 3 -> cas_lat updated. Any other value -> cmd_err, cas_lat unchanged, state unchanged.
REQ-022 IDLE:
  - ACTIVE -> latch row, load counter with T_RCD-1, go to ACTIVATING.
  - AUTO REFRESH -> load counter with T_RFC-1, go to REFRESHING.
  - LOAD MODE per REQ-021.
  - PRECHARGE -> no-op.
  - READ/WRITE -> cmd_err.
REQ-023 ACTIVATING / REFRESHING:
  - The counter decrements each enabled cycle.
  - At 0: ACTIVATING -> ROW_ACTIVE; REFRESHING -> IDLE.
  - Any non-NOP/DESELECT command in these states -> cmd_err, ignored.
REQ-024 ROW_ACTIVE:
  - WRITE stores mem_dq_i in the same cycle.
  - READ enqueues {row,col} into the read pipeline.
  - PRECHARGE -> IDLE.
  - ACTIVE, AUTO REFRESH or LOAD MODE -> cmd_err, ignored.
REQ-025 Read latency: for a READ sampled at edge N, mem_dq_o is valid and mem_dq_oe=1 for exactly the cycle after edge N+cas_lat.
REQ-026 Back-to-back READs produce back-to-back data with no bubbles.
REQ-027 The read pipeline is 3 stages. It is not flushed by PRECHARGE; data already issued is still delivered.
REQ-028 READ then WRITE to the same address on the next cycle: the read returns the old data.
REQ-029 WRITE then READ to the same address on the next cycle: the read returns the new data.
REQ-030 cas_lat change while reads are in flight: each in-flight read keeps the latency it was issued with.
REQ-031 When mem_dq_oe=0, mem_dq_o shall be 0.
REQ-032 cmd_err is registered and asserts the cycle after the offending command.

Reset
REQ-033 On nrst=0, immediately:
  - state=INIT, counter=0, read pipeline cleared;
  - mem_dq_oe=0, mem_dq_o=0, cmd_err=0, cas_lat=2.
  Storage contents are not reset.
REQ-034 Reset asserted mid-read: no data is delivered after nrst deasserts.

Verification
REQ-035 Bring-up and read latency 2:
  - Stimulus: reset, LOAD MODE addr=0x020, ACTIVE row 3, 1 NOP, WRITE col 5 data 0xBEEF, READ col 5.
  - Response: mem_dq_o=0xBEEF with oe=1 exactly 2 cycles after READ.
REQ-036 Latency 3 with back-to-back reads:
  - Stimulus: LOAD MODE addr=0x030, then 4 consecutive READs.
  - Response: cas_lat=3; 4 consecutive valid words starting 3 cycles after the first READ.
REQ-037 Illegal commands, each producing a one-cycle cmd_err with no state or data change:
  - READ in IDLE;
  - WRITE during ACTIVATING;
  - ACTIVE in ROW_ACTIVE;
  - LOAD MODE with mem_addr[6:4]=5;
  - READ in INIT.
REQ-038 Refresh timing:
  - Stimulus: AUTO REFRESH in IDLE, then ACTIVE on the next cycle.
  - Response: cmd_err on the ACTIVE; an ACTIVE issued T_RFC cycles after the refresh is accepted.
REQ-039 Clock enable freeze:
  - Stimulus: mem_cke=0 for 3 cycles right after a READ (latency 2).
  - Response: data is delayed by 3 cycles; commands presented while cke=0 are ignored.
REQ-040 Precharge and reset during reads:
  - PRECHARGE immediately after a READ: the data is still delivered.
  - nrst pulse 1 cycle after a READ: oe stays 0 and state returns to INIT.
